spi_flash_reader: RTL and testbench
===================================

// Module: spi_flash_reader
// PURPOSE
//  SPI mode-0 master that issues single 03h READ transactions to the serial NOR
//  flash on the SPI bus and returns one 32-bit word per request. Sits between a
//  valid/ready fetch or load port and the off-chip flash pins: sck, ss_n, mosi, miso.
//  Every frame is exactly 64 sck periods: 8 cmd + 24 addr + 32 data bits, MSB first.
// PARAMETERS
//  DIV    2  sck half-period in clock cycles; legal values >= 1
//  BSWAP  0  1: resp_data = byte-reversed received word; 0: as received
// PORTS
//  clock      in   1   system clock; all state changes on its rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  req_valid  in   1   read request
//  req_ready  out  1   high only in IDLE
//  req_addr   in   24  flash byte address; latched on accept
//  resp_valid out  1   read data available; held until accepted
//  resp_ready in   1   consumer accepts resp_data
//  resp_data  out  32  received word
//  sck        out  1   SPI clock; registered, idles low
//  ss_n       out  1   chip select, active low; registered, idles high
//  mosi       out  1   serial data to flash; registered
//  miso       in   1   serial data from flash; flash drives 1 while deselected
// BEHAVIOUR
//  Reset: async on reset_n low. State IDLE; sck=0, ss_n=1, mosi=0, resp_valid=0,
//   resp_data=0, internal counters 0. Reset mid-frame aborts with no resp; the flash
//   resynchronises when ss_n rises.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: req_ready=1. On req_valid: latch tx={8'h03,req_addr}; ss_n<=0, sck stays 0,
//   mosi<=tx[31], bit_cnt<=0, div_cnt<=0; go to SHIFT. This is the accept edge, E0.
//  SHIFT: div_cnt counts 0..DIV-1; the toggle happens on the edge where it wraps.
//   Rising toggle (sck 0->1), bit k: if k>=32, rx<={rx[30:0],miso}. miso is sampled
//   on the same edge that raises sck, i.e. the value from before the flash's posedge.
//   Falling toggle (sck 1->0): if k<31, shift tx and mosi<=next bit;
//   if k>=31, mosi<=0. Then bit_cnt<=k+1.
//   Falling toggle of bit 63: ss_n<=1 and resp_valid<=1 on the same edge;
//   resp_data<=BSWAP ? byte-reversed rx : rx; go to DONE.
//  Timing: rising edge of bit k at E0+(2k+1)*DIV; falling edge at E0+(2k+2)*DIV.
//   resp_valid is high after edge E0+128*DIV.
//  DONE: ss_n=1, sck=0, req_ready=0. resp_valid/resp_data are held stable until
//   resp_ready=1, then IDLE. So ss_n is high for >=1 cycle between frames.
//  Simultaneous events: req_valid is ignored outside IDLE. A resp_ready during
//   SHIFT has no effect. A request in the cycle after a DONE handshake is accepted.
//  ss_n, sck and mosi never change in the same cycle as reset_n is asserted, other
//   than to their reset values.
//  Width: bit_cnt 6 bits; div_cnt is wide enough for DIV-1; no wrap inside a frame.
// TESTING
//  1 DIV=1, flash model holds 0x12345678 at 0x000010. Request addr 0x000010 ->
//    mosi on 32 rising edges = 03h,000010h; resp_valid at E0+128; resp_data=0x12345678.
//  2 DIV=3, addr 0xABCDEC -> sck high/low exactly 3 cycles each; 64 rising edges
//    while ss_n=0; resp_valid at E0+384; model sees no unsupported-cmd fatal.
//  3 resp_ready held 0 for 20 cycles after resp_valid -> resp_valid/resp_data
//    stable; req_ready=0; ss_n=1; no sck edges.
//  4 Back-to-back requests at 0x0 and 0x4, resp_ready=1 -> two frames separated by
//    ss_n high >=1 cycle; data = words at 0x0 and 0x4 in order.
//  5 reset_n low at bit 40 of a frame -> ss_n=1, sck=0 immediately, no resp;
//    the next request after release returns the correct word.
//  6 BSWAP=1, word 0x11223344 -> resp_data=0x44332211.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
// Request/response handshake between a fetch or load client and spi_flash_reader.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master issuing single 03h READ frames (8 cmd + 24 addr + 32 data bits)
// to a serial NOR flash; returns one 32-bit word per accepted request.
module spi_flash_reader #(
  parameter int unsigned DIV   = 2,
  parameter bit          BSWAP = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  spi_flash_reader_if.slave bus,
  output logic              sck,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned      BIT_W    = 6;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        tx_q, tx_d;
  logic [31:0]        rx_q, rx_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               sck_q, sck_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               req_ready_q, req_ready_d;

  // State and pin registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      sck_q        <= 1'b0;
      ss_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      sck_q        <= sck_d;
      ss_n_q       <= ss_n_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // Next-state: sck toggles each time div_cnt wraps; miso sampled on rising toggles
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    sck_d        = sck_q;
    ss_n_d       = ss_n_q;
    mosi_d       = mosi_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tx_d      = {CMD_READ, bus.req_addr};
          ss_n_d    = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = tx_d[31];
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            if (bit_cnt_q >= BIT_W'(32)) begin
              rx_d = {rx_q[30:0], miso};
            end
          end else begin
            if (bit_cnt_q < BIT_W'(31)) begin
              tx_d   = {tx_q[30:0], 1'b0};
              mosi_d = tx_q[30];
            end else begin
              mosi_d = 1'b0;
            end
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(63)) begin
              ss_n_d       = 1'b1;
              resp_valid_d = 1'b1;
              resp_data_d  = BSWAP ? {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]} : rx_q;
              state_d      = DONE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  assign sck            = sck_q;
  assign ss_n           = ss_n_q;
  assign mosi           = mosi_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: instance 0 (DIV=1, BSWAP=0) and
// instance 1 (DIV=3, BSWAP=1), each talking to a behavioural 03h-read flash.
module tb_spi_flash_reader;

  typedef struct {
    int          inst;
    logic [23:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [23:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic        sck        [2];
  logic        ss_n       [2];
  logic        mosi       [2];
  logic        miso_r     [2] = '{1'b1, 1'b1};

  exp_t        sb_q [$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          fin = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned GDIV  = (g == 0) ? 1 : 3;
    localparam bit          GSWAP = (g == 0) ? 1'b0 : 1'b1;
    spi_flash_reader_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_data[g]   = bus.resp_data;
    spi_flash_reader #(.DIV(GDIV), .BSWAP(GSWAP)) u_dut (
      .clock  (clock),
      .reset_n(rst_n[g]),
      .bus    (bus),
      .sck    (sck[g]),
      .ss_n   (ss_n[g]),
      .mosi   (mosi[g]),
      .miso   (miso_r[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    case (a)
      24'h000000: return 32'hA5A50F0F;
      24'h000004: return 32'h11223344;
      24'h000010: return 32'h12345678;
      24'hABCDEC: return 32'hDEADBEEF;
      default:    return {8'h5A, a};
    endcase
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s[%0d]: got %h expected %h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  // Flash model and response monitor; all comparisons happen here
  logic        psck [2], pss [2], prv [2];
  logic        prst [2] = '{1'b1, 1'b1};
  bit          act [2], had_frame [2];
  int unsigned e0 [2], last_edge [2], ss_rise [2];
  int          fl_bits [2], rises [2], badw [2], holdbad [2];
  logic [31:0] shreg [2], dout [2], held [2];
  bit          fin_done = 1'b0;

  always @(negedge clock) begin : monitor
    int unsigned dv;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? 1 : 3;
      if (!rst_n[i]) begin
        if (prst[i]) begin
          chk("rst_ssn",   i, 32'(ss_n[i]),       32'd1);
          chk("rst_sck",   i, 32'(sck[i]),        32'd0);
          chk("rst_mosi",  i, 32'(mosi[i]),       32'd0);
          chk("rst_rvld",  i, 32'(resp_valid[i]), 32'd0);
          chk("rst_rdata", i, resp_data[i],       32'd0);
          chk("rst_rdy",   i, 32'(req_ready[i]),  32'd1);
          if (act[i] && sb_q.size() > 0) void'(sb_q.pop_front());
        end
        act[i]     = 1'b0;
        fl_bits[i] = 0;
        miso_r[i]  = 1'b1;
        psck[i]    = 1'b0;
        pss[i]     = 1'b1;
        prv[i]     = 1'b0;
      end else begin
        if (act[i] && (sck[i] != psck[i])) begin
          if (cyc - last_edge[i] != dv) badw[i] = badw[i] + 1;
          last_edge[i] = cyc;
          if (sck[i]) begin
            rises[i] = rises[i] + 1;
            if (fl_bits[i] < 32) begin
              shreg[i]   = {shreg[i][30:0], mosi[i]};
              fl_bits[i] = fl_bits[i] + 1;
              if (fl_bits[i] == 32) begin
                chk("cmd", i, 32'(shreg[i][31:24]), 32'h03);
                chk("sb_has_req", i, 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) chk("addr", i, 32'(shreg[i][23:0]), 32'(sb_q[0].addr));
                dout[i] = flash_word(shreg[i][23:0]);
              end
            end else begin
              fl_bits[i] = fl_bits[i] + 1;
            end
          end else if (fl_bits[i] >= 32 && fl_bits[i] < 64) begin
            miso_r[i] = dout[i][31];
            dout[i]   = {dout[i][30:0], 1'b0};
          end
        end
        if (pss[i] && !ss_n[i]) begin
          if (had_frame[i]) chk("ssgap", i, 32'((cyc - ss_rise[i]) >= 2), 32'd1);
          act[i]       = 1'b1;
          e0[i]        = cyc;
          last_edge[i] = cyc;
          fl_bits[i]   = 0;
          rises[i]     = 0;
          badw[i]      = 0;
        end
        if (!pss[i] && ss_n[i] && act[i]) begin
          chk("sck_rises", i, 32'(rises[i]), 32'd64);
          chk("sck_width", i, 32'(badw[i]),  32'd0);
          act[i]       = 1'b0;
          had_frame[i] = 1'b1;
          ss_rise[i]   = cyc;
        end
        if (ss_n[i]) miso_r[i] = 1'b1;
        if (resp_valid[i] && !prv[i]) begin
          chk("latency", i, cyc - e0[i], 32'(128 * dv));
          held[i]    = resp_data[i];
          holdbad[i] = 0;
        end else if (resp_valid[i] && prv[i]) begin
          if (resp_data[i] !== held[i] || sck[i] || !ss_n[i] || req_ready[i])
            holdbad[i] = holdbad[i] + 1;
        end
        if (resp_valid[i] && resp_ready[i]) begin
          chk("sb_nonempty", i, 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("inst", i, 32'(e.inst), 32'(i));
            chk("data", i, resp_data[i], e.data);
            chk("hold", i, 32'(holdbad[i]), 32'd0);
          end
        end
        psck[i] = sck[i];
        pss[i]  = ss_n[i];
        prv[i]  = resp_valid[i];
      end
      prst[i] = rst_n[i];
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      chk("sb_empty", 0, 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic timeout(input string what);
    $display("FAIL timeout: %s still pending at cycle %0d", what, cyc);
    $fatal(1, "bench stopped");
  endtask

  // Inputs change 1 time unit after posedge so the monitor sees them settled
  task automatic do_req(input int i, input logic [23:0] a, input logic [31:0] d);
    bit acc;
    sb_q.push_back('{inst: i, addr: a, data: d});
    req_addr[i]  = a;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      acc = req_ready[i];
      @(posedge clock); #1;
      if (acc) begin
        req_valid[i] = 1'b0;
        return;
      end
    end
    timeout("request accept");
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 5000; t++) begin
      if (sb_q.size() == 0 && !resp_valid[0] && !resp_valid[1]) return;
      @(posedge clock); #1;
    end
    timeout("response drain");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i]      = 1'b1;
      req_valid[i]  = 1'b0;
      req_addr[i]   = '0;
      resp_ready[i] = 1'b1;
    end
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clock); #1;

    do_req(0, 24'h000010, 32'h12345678);
    wait_empty();

    do_req(1, 24'hABCDEC, 32'hEFBEADDE);
    wait_empty();

    // Consumer stalls for 20 cycles with the word presented
    resp_ready[0] = 1'b0;
    do_req(0, 24'h000020, 32'h5A000020);
    begin : stall_wait
      for (int t = 0; t < 5000; t++) begin
        if (resp_valid[0]) disable stall_wait;
        @(posedge clock); #1;
      end
      timeout("stalled response");
    end
    repeat (20) @(posedge clock);
    #1;
    resp_ready[0] = 1'b1;
    wait_empty();

    do_req(0, 24'h000000, 32'hA5A50F0F);
    do_req(0, 24'h000004, 32'h11223344);
    wait_empty();

    // Reset in the middle of the data phase aborts the frame silently
    do_req(0, 24'h000010, 32'h12345678);
    begin : bit40_wait
      for (int t = 0; t < 5000; t++) begin
        if (fl_bits[0] >= 40) disable bit40_wait;
        @(posedge clock); #1;
      end
      timeout("bit 40");
    end
    @(posedge clock); #2;
    rst_n[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clock); #1;
    do_req(0, 24'h000004, 32'h11223344);
    wait_empty();

    do_req(1, 24'h000004, 32'h44332211);
    do_req(1, 24'h000010, 32'h78563412);
    wait_empty();

    repeat (4) @(posedge clock);
    #1;
    fin = 1'b1;
    repeat (4) @(posedge clock);
    $display("FAIL end: monitor did not close the run");
    $fatal(1, "bench stopped");
  end

endmodule
